// File: rtl/vpq_pkg.sv
// vpq_pkg
// Shared definitions for the virtual priority queue bank: default parameter
// values, the queue index mapping used by o_req/o_full, the one-hot legality
// check applied to port/priority selects, and the per-queue count width.
package vpq_pkg;

  localparam int PORT_DEFAULT       = 8;
  localparam int PRIORITY_DEFAULT   = 4;
  localparam int WIDTH_DEFAULT      = 32;
  localparam int DEPTH_BITS_DEFAULT = 3;
  localparam int CNT_WIDTH_DEFAULT  = 16;

  // A count must represent 0..2^DEPTH_BITS inclusive, hence one extra bit.
  localparam int COUNT_BITS_DEFAULT = DEPTH_BITS_DEFAULT + 1;

  // Widest select vector the legality check accepts; callers zero-extend.
  localparam int SEL_MAX = 64;

  function automatic int count_bits(input int depth_bits);
    return depth_bits + 1;
  endfunction

  // Flat queue index: all ports of priority 0 first, then priority 1, ...
  function automatic int qidx(input int prio, input int port, input int n_port);
    return prio * n_port + port;
  endfunction

  // A select is legal only when exactly one bit is set.
  function automatic logic is_onehot(input logic [SEL_MAX-1:0] sel);
    int ones;
    ones = 0;
    for (int i = 0; i < SEL_MAX; i++) begin
      ones = ones + int'(sel[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/vpq_fifo.sv
// vpq_fifo
// One circular FIFO of the queue bank.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : store wr_data at the write pointer (caller guarantees room,
//                or a same-cycle read when full)
//   rd_en      : retire the head entry (caller guarantees non-empty)
//   wr_data    : cell to store
//   head       : combinational view of the oldest entry
//   count      : occupancy 0..2^DEPTH_BITS
//   full/empty : decoded from count
module vpq_fifo
  import vpq_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_BITS = DEPTH_BITS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic [WIDTH-1:0]                 wr_data,
  output logic [WIDTH-1:0]                 head,
  output logic [count_bits(DEPTH_BITS)-1:0] count,
  output logic                             full,
  output logic                             empty
);

  localparam int CB    = count_bits(DEPTH_BITS);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;

  // Storage is not reset; contents are meaningless once the pointers clear.
  // When full with a simultaneous read, wr_ptr == rd_ptr: the old head is
  // read out through 'head' before this edge overwrites that slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (rd_en) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CB'(1);
        2'b01:   count <= count - CB'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CB'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vpq_buffer.sv
// vpq_buffer
// Virtual priority queue bank: one FIFO per (output port, priority) pair.
//   clk, reset        : clock, asynchronous active-high reset
//   i_wr, i_wr_port,
//   i_wr_priority,
//   i_data            : enqueue request with one-hot port/priority selects
//   i_rd, i_rd_port,
//   i_rd_priority     : dequeue grant with one-hot port/priority selects
//   o_req / o_full    : per-queue non-empty / full, index priority*PORT+port
//   o_data, o_valid   : registered dequeued cell and its strobe
//   o_drop            : pulse, write discarded because the queue was full
//   o_drop_cnt        : saturating count of discarded writes
//   o_err             : pulse, illegal select or read of an empty queue
module vpq_buffer
  import vpq_pkg::*;
#(
  parameter int PORT       = PORT_DEFAULT,
  parameter int PRIORITY   = PRIORITY_DEFAULT,
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_BITS = DEPTH_BITS_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr,
  input  logic [PORT-1:0]          i_wr_port,
  input  logic [PRIORITY-1:0]      i_wr_priority,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_rd,
  input  logic [PORT-1:0]          i_rd_port,
  input  logic [PRIORITY-1:0]      i_rd_priority,
  output logic [PORT*PRIORITY-1:0] o_req,
  output logic [PORT*PRIORITY-1:0] o_full,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_drop,
  output logic [CNT_WIDTH-1:0]     o_drop_cnt,
  output logic                     o_err
);

  localparam int NQ = PORT * PRIORITY;
  localparam int CB = count_bits(DEPTH_BITS);

  logic wr_legal;
  logic rd_legal;
  logic wr_strobe;
  logic rd_strobe;

  logic [NQ-1:0]    wr_sel;
  logic [NQ-1:0]    rd_sel;
  logic [NQ-1:0]    wr_fire;
  logic [NQ-1:0]    rd_fire;
  logic [NQ-1:0]    q_full;
  logic [NQ-1:0]    q_empty;
  logic [WIDTH-1:0] q_head [NQ];
  logic [CB-1:0]    q_count [NQ];

  logic [WIDTH-1:0] read_mux;
  logic             drop_now;
  logic             err_now;

  assign wr_legal  = is_onehot(SEL_MAX'(i_wr_port)) && is_onehot(SEL_MAX'(i_wr_priority));
  assign rd_legal  = is_onehot(SEL_MAX'(i_rd_port)) && is_onehot(SEL_MAX'(i_rd_priority));
  assign wr_strobe = i_wr && wr_legal;
  assign rd_strobe = i_rd && rd_legal;

  for (genvar r = 0; r < PRIORITY; r++) begin : g_prio
    for (genvar p = 0; p < PORT; p++) begin : g_port
      localparam int Q = qidx(r, p, PORT);

      assign wr_sel[Q]  = wr_strobe && i_wr_port[p] && i_wr_priority[r];
      assign rd_sel[Q]  = rd_strobe && i_rd_port[p] && i_rd_priority[r];
      // No bypass: an empty queue never serves a read, even if written now.
      assign rd_fire[Q] = rd_sel[Q] && !q_empty[Q];
      // A full queue still accepts a write when its head leaves this cycle.
      assign wr_fire[Q] = wr_sel[Q] && (!q_full[Q] || rd_fire[Q]);

      vpq_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire[Q]),
        .rd_en   (rd_fire[Q]),
        .wr_data (i_data),
        .head    (q_head[Q]),
        .count   (q_count[Q]),
        .full    (q_full[Q]),
        .empty   (q_empty[Q])
      );

      assign o_req[Q]  = (q_count[Q] != '0);
      assign o_full[Q] = q_full[Q];
    end
  end

  // At most one rd_fire bit is set, so an AND-OR tree selects the head.
  always_comb begin
    read_mux = '0;
    for (int q = 0; q < NQ; q++) begin
      read_mux = read_mux | (q_head[q] & {WIDTH{rd_fire[q]}});
    end
  end

  assign drop_now = |(wr_sel & ~wr_fire);
  assign err_now  = (i_wr && !wr_legal) || (i_rd && !rd_legal) ||
                    (rd_strobe && !(|rd_fire));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_drop     <= 1'b0;
      o_err      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_valid <= |rd_fire;
      o_drop  <= drop_now;
      o_err   <= err_now;
      if (|rd_fire) begin
        o_data <= read_mux;
      end
      if (drop_now && (o_drop_cnt != {CNT_WIDTH{1'b1}})) begin
        o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vpq_buffer.sv
// tb_vpq_buffer
// Self-checking bench for vpq_buffer (CNT_WIDTH reduced to 4 so that the
// drop counter saturates quickly). A queue-based reference model tracks
// every queue's contents and derives all expected outputs.
module tb_vpq_buffer;

  localparam int P     = 8;
  localparam int R     = 4;
  localparam int W     = 32;
  localparam int DB    = 3;
  localparam int CW    = 4;
  localparam int NQ    = P * R;
  localparam int DEPTH = 1 << DB;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          i_wr;
  logic [P-1:0]  i_wr_port;
  logic [R-1:0]  i_wr_priority;
  logic [W-1:0]  i_data;
  logic          i_rd;
  logic [P-1:0]  i_rd_port;
  logic [R-1:0]  i_rd_priority;
  logic [NQ-1:0] o_req;
  logic [NQ-1:0] o_full;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic          o_drop;
  logic [CW-1:0] o_drop_cnt;
  logic          o_err;

  vpq_buffer #(
    .PORT(P), .PRIORITY(R), .WIDTH(W), .DEPTH_BITS(DB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wr(i_wr), .i_wr_port(i_wr_port), .i_wr_priority(i_wr_priority), .i_data(i_data),
    .i_rd(i_rd), .i_rd_port(i_rd_port), .i_rd_priority(i_rd_priority),
    .o_req(o_req), .o_full(o_full), .o_data(o_data), .o_valid(o_valid),
    .o_drop(o_drop), .o_drop_cnt(o_drop_cnt), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [W-1:0] cell_q_t [$];
  cell_q_t     mq [NQ];
  int          drop_cnt_m;
  logic [W-1:0] data_m;
  logic        exp_valid, exp_err, exp_drop;

  typedef struct {
    logic         wr;
    logic [P-1:0] wp;
    logic [R-1:0] wpr;
    logic [W-1:0] d;
    logic         rd;
    logic [P-1:0] rp;
    logic [R-1:0] rpr;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_err;
    logic         e_drop;
    logic         e_req10;
  } vec_t;

  vec_t vecs [5];

  function automatic int sel_idx(input logic [P-1:0] v);
    for (int i = 0; i < P; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int q = 0; q < NQ; q++) mq[q].delete();
    drop_cnt_m = 0;
    data_m     = '0;
  endtask

  task automatic checkOutput(input string tag);
    logic [NQ-1:0] e_req, e_full;
    for (int q = 0; q < NQ; q++) begin
      e_req[q]  = (mq[q].size() != 0);
      e_full[q] = (mq[q].size() == DEPTH);
    end
    checkVal({tag, "_valid"}, 64'(o_valid), 64'(exp_valid));
    checkVal({tag, "_data"}, 64'(o_data), 64'(data_m));
    checkVal({tag, "_err"}, 64'(o_err), 64'(exp_err));
    checkVal({tag, "_drop"}, 64'(o_drop), 64'(exp_drop));
    checkVal({tag, "_dropcnt"}, 64'(o_drop_cnt), 64'(drop_cnt_m));
    checkVal({tag, "_req"}, 64'(o_req), 64'(e_req));
    checkVal({tag, "_full"}, 64'(o_full), 64'(e_full));
  endtask

  // One clock of stimulus: drive at the falling edge, update the model with
  // the queue semantics, then compare just after the rising edge.
  task automatic applyStimulus(input logic wr, input logic [P-1:0] wp, input logic [R-1:0] wpr,
                               input logic [W-1:0] d, input logic rd, input logic [P-1:0] rp,
                               input logic [R-1:0] rpr, input string tag);
    logic wsel_ok, rsel_ok, rd_ok, wr_ok;
    int   wi, ri;
    @(negedge clk);
    i_wr = wr; i_wr_port = wp; i_wr_priority = wpr; i_data = d;
    i_rd = rd; i_rd_port = rp; i_rd_priority = rpr;

    wsel_ok = ($countones(wp) == 1) && ($countones(wpr) == 1);
    rsel_ok = ($countones(rp) == 1) && ($countones(rpr) == 1);
    wi = sel_idx(P'(wpr)) * P + sel_idx(wp);
    ri = sel_idx(P'(rpr)) * P + sel_idx(rp);
    rd_ok = rd && rsel_ok && (mq[ri].size() > 0);
    wr_ok = wr && wsel_ok && ((mq[wi].size() < DEPTH) || (rd_ok && ri == wi));
    exp_drop  = wr && wsel_ok && !wr_ok;
    exp_err   = (wr && !wsel_ok) || (rd && !rsel_ok) || (rd && rsel_ok && !rd_ok);
    exp_valid = rd_ok;
    if (rd_ok) data_m = mq[ri].pop_front();
    if (wr_ok) mq[wi].push_back(d);
    if (exp_drop && drop_cnt_m < CMAX) drop_cnt_m++;

    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_req"}, 64'(o_req), 64'd0);
    checkVal({tag, "_full"}, 64'(o_full), 64'd0);
    checkVal({tag, "_data"}, 64'(o_data), 64'd0);
    checkVal({tag, "_valid"}, 64'(o_valid), 64'd0);
    checkVal({tag, "_drop"}, 64'(o_drop), 64'd0);
    checkVal({tag, "_dropcnt"}, 64'(o_drop_cnt), 64'd0);
    checkVal({tag, "_err"}, 64'(o_err), 64'd0);
  endtask

  function automatic logic [P-1:0] pick_port();
    int r = $urandom_range(0, 15);
    if (r == 0) return P'($urandom);
    if (r < 8)  return 8'h01;
    if (r < 12) return 8'h04;
    return 8'h80;
  endfunction

  function automatic logic [R-1:0] pick_prio();
    int r = $urandom_range(0, 15);
    if (r == 0) return R'($urandom);
    if (r < 10) return 4'h1;
    return 4'h2;
  endfunction

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), pick_port(), pick_prio(), $urandom,
                    ($urandom_range(0, 9) < 5), pick_port(), pick_prio(), "rand");
    end
  endtask

  initial begin
    reset = 1'b1;
    i_wr = 1'b0; i_wr_port = '0; i_wr_priority = '0; i_data = '0;
    i_rd = 1'b0; i_rd_port = '0; i_rd_priority = '0;
    modelReset();
    exp_valid = 1'b0; exp_err = 1'b0; exp_drop = 1'b0;

    #2;
    checkResetState("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors starting from an empty bank.
    vecs[0] = '{1'b1, 8'h04, 4'h2, 32'hA5A5A5A5, 1'b0, 8'h00, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b1, 8'h04, 4'h2, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 4'h1, 32'h12345678, 1'b0, 8'h00, 4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b1, 8'h01, 4'h1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b0, 8'h00, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wp, vecs[i].wpr, vecs[i].d,
                    vecs[i].rd, vecs[i].rp, vecs[i].rpr, "tbl");
      checkVal("tbl_vec_valid", 64'(o_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) checkVal("tbl_vec_data", 64'(o_data), 64'(vecs[i].e_data));
      checkVal("tbl_vec_err", 64'(o_err), 64'(vecs[i].e_err));
      checkVal("tbl_vec_drop", 64'(o_drop), 64'(vecs[i].e_drop));
      checkVal("tbl_vec_req10", 64'(o_req[10]), 64'(vecs[i].e_req10));
    end

    // Fill queue 0, overflow once, then drain with pointer wrap.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'h01, 4'h1, W'(i), 1'b0, 8'h00, 4'h0, "fill");
    checkVal("full_after_8", 64'(o_full[0]), 64'd1);
    applyStimulus(1'b1, 8'h01, 4'h1, 32'd9, 1'b0, 8'h00, 4'h0, "overflow");
    checkVal("overflow_drop", 64'(o_drop), 64'd1);
    checkVal("overflow_cnt", 64'(o_drop_cnt), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 8'h00, 4'h0, 32'd0, 1'b1, 8'h01, 4'h1, "drain");
      checkVal("drain_order", 64'(o_data), 64'(i));
    end
    checkVal("drained_req", 64'(o_req[0]), 64'd0);

    // Full queue with simultaneous write and read.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'h01, 4'h1, W'(32'h10 + i), 1'b0, 8'h00, 4'h0, "refill");
    applyStimulus(1'b1, 8'h01, 4'h1, 32'h99, 1'b1, 8'h01, 4'h1, "full_rw");
    checkVal("full_rw_data", 64'(o_data), 64'h11);
    checkVal("full_rw_drop", 64'(o_drop), 64'd0);
    checkVal("full_rw_full", 64'(o_full[0]), 64'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 4'h0, 32'd0, 1'b1, 8'h01, 4'h1, "drain2");
    checkVal("last_is_99", 64'(o_data), 64'h99);

    // Write and read the same empty queue: no bypass.
    applyStimulus(1'b1, 8'h01, 4'h1, 32'h77, 1'b1, 8'h01, 4'h1, "nobypass");
    checkVal("nobypass_valid", 64'(o_valid), 64'd0);
    applyStimulus(1'b0, 8'h00, 4'h0, 32'd0, 1'b1, 8'h01, 4'h1, "nobypass_rd");

    // Saturate the drop counter.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h01, 4'h1, W'(i), 1'b0, 8'h00, 4'h0, "satfill");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h01, 4'h1, W'(i), 1'b0, 8'h00, 4'h0, "satdrop");
    checkVal("drop_cnt_sat", 64'(o_drop_cnt), 64'(CMAX));

    randomCycles(1500);

    // Asynchronous reset mid-stream: outputs clear with no clock edge.
    #2;
    reset = 1'b1;
    #1;
    checkResetState("midreset");
    i_wr = 1'b0; i_rd = 1'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    randomCycles(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
